// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the I-cache with pc/fetch_en, queues returned
// words toward decode, holds pc across cache refills and handles redirects.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pc,
    output logic            fetch_en,
    input  logic            ic_ready,
    input  logic            ic_miss,
    input  logic [31:0]     ic_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    input  logic            id_ready
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FILL       = 2'd1,
        FILL_FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] mem_pc    [QDEPTH];
    logic [31:0]     mem_instr [QDEPTH];

    logic [XLEN-1:0] redir_tgt;
    logic            push;
    logic            pop;

    assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // Fetch request stays high through a refill so the cache can finish the held line.
    assign fetch_en = reset & ((state != RUN) | ((count < CW'(QDEPTH)) & ~redirect_valid));

    // Queue head is read straight out of storage; no path from ic_* to if_*.
    assign if_valid = (count != '0);
    assign if_pc    = mem_pc[rd_ptr];
    assign if_instr = mem_instr[rd_ptr];

    // Push/pop qualification; a redirect flushes and overrides both.
    always_comb begin
        push = 1'b0;
        pop  = 1'b0;
        if (!redirect_valid) begin
            pop = if_valid & id_ready;
            case (state)
                RUN:     push = fetch_en & ic_ready;
                FILL:    push = ic_ready;
                default: push = 1'b0;
            endcase
        end
    end

    // Fetch queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= pc;
                mem_instr[wr_ptr] <= ic_instr;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Fetch FSM: pc sequencing, refill hold and pending-redirect tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            pc      <= RESET_PC;
            pend_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        pc <= redir_tgt;
                    end else if (push) begin
                        pc <= pc + XLEN'(4);
                    end else if (fetch_en && ic_miss) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (redirect_valid) begin
                        pend_pc <= redir_tgt;
                        state   <= FILL_FLUSH;
                    end else if (ic_ready) begin
                        pc    <= pc + XLEN'(4);
                        state <= RUN;
                    end
                end
                FILL_FLUSH: begin
                    if (redirect_valid) begin
                        pend_pc <= redir_tgt;
                        if (ic_ready) begin
                            pc    <= redir_tgt;
                            state <= RUN;
                        end
                    end else if (ic_ready) begin
                        pc    <= pend_pc;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all checked against a queue-based model every cycle.
module tb_fetch_unit;

    localparam int unsigned QDEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        fetch_en;
    logic        ic_ready;
    logic        ic_miss;
    logic [31:0] ic_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    int vectors = 0;
    int errors  = 0;

    // Model: pc, fill mode (0 fetching, 1 refilling, 2 refilling with redirect pending), queue.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    int          m_mode;
    logic [63:0] m_q [$];

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en),
        .ic_ready(ic_ready), .ic_miss(ic_miss), .ic_instr(ic_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .id_ready(id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT outputs against the model for the inputs currently applied.
    task automatic model_check();
        logic fe;
        fe = (m_mode != 0) || ((m_q.size() < QDEPTH) && !redirect_valid);
        chk("fetch_en", 32'(fetch_en), 32'(fe));
        chk("pc", pc, m_pc);
        chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("if_pc", if_pc, m_q[0][63:32]);
            chk("if_instr", if_instr, m_q[0][31:0]);
        end
    endtask

    // Advance the model by one clock using the rules of the fetch stage.
    task automatic model_update(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic miss, input logic [31:0] instr, input logic idr);
        logic        fe;
        logic [31:0] tgt;
        fe  = (m_mode != 0) || ((m_q.size() < QDEPTH) && !rv);
        tgt = rpc & 32'hFFFF_FFFC;
        if (rv) begin
            m_q.delete();
            if (m_mode == 0) begin
                m_pc = tgt;
            end else if (m_mode == 1) begin
                m_pend = tgt;
                m_mode = 2;
            end else begin
                m_pend = tgt;
                if (rdy) begin
                    m_pc   = tgt;
                    m_mode = 0;
                end
            end
        end else begin
            if (idr && m_q.size() != 0) void'(m_q.pop_front());
            if (m_mode == 0) begin
                if (fe && rdy) begin
                    m_q.push_back({m_pc, instr});
                    m_pc = m_pc + 32'd4;
                end else if (fe && miss) begin
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (rdy) begin
                    m_q.push_back({m_pc, instr});
                    m_pc   = m_pc + 32'd4;
                    m_mode = 0;
                end
            end else if (rdy) begin
                m_pc   = m_pend;
                m_mode = 0;
            end
        end
    endtask

    // One cycle: drive, check before the edge, advance model, return inputs to idle.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy,
                        input logic miss, input logic [31:0] instr, input logic idr);
        redirect_valid = rv;
        redirect_pc    = rpc;
        ic_ready       = rdy;
        ic_miss        = miss;
        ic_instr       = instr;
        id_ready       = idr;
        #1;
        model_check();
        @(posedge clk);
        model_update(rv, rpc, rdy, miss, instr, idr);
        #1;
        redirect_valid = 1'b0;
        ic_ready       = 1'b0;
        ic_miss        = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ic_ready       = 1'b0;
        ic_miss        = 1'b0;
        ic_instr       = '0;
        id_ready       = 1'b0;
        m_pc   = 32'h0;
        m_pend = 32'h0;
        m_mode = 0;
        m_q.delete();

        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_fetch_en", 32'(fetch_en), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        reset = 1'b1;
        #1;
        chk("rel_fetch_en", 32'(fetch_en), 32'h1);
        chk("rel_pc", pc, 32'h0);

        // Back-to-back hits with decode always ready.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hAAAA_0000, 1'b1);
        chk("hit0_if_pc", if_pc, 32'h0);
        chk("hit0_if_instr", if_instr, 32'hAAAA_0000);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hAAAA_0004, 1'b1);
        chk("hit1_if_pc", if_pc, 32'h4);
        chk("hit1_if_instr", if_instr, 32'hAAAA_0004);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hAAAA_0008, 1'b1);
        chk("hit2_if_pc", if_pc, 32'h8);
        chk("hit2_pc", pc, 32'hC);

        // Decode stalled: two hits fill the queue, then drain.
        step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hBBBB_0000, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hBBBB_0004, 1'b0);
        chk("full_fetch_en", 32'(fetch_en), 32'h0);
        chk("full_pc", pc, 32'h8);
        chk("full_if_pc", if_pc, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_if_pc", if_pc, 32'h4);
        chk("drain_fetch_en", 32'(fetch_en), 32'h1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("drain_empty", 32'(if_valid), 32'h0);
        chk("resume_pc", pc, 32'h8);

        // Miss at 0x40: pc and fetch_en held for four refill beats.
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("fill_pc", pc, 32'h40);
            chk("fill_fetch_en", 32'(fetch_en), 32'h1);
            step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hCCCC_0040, 1'b0);
        chk("refill_if_pc", if_pc, 32'h40);
        chk("refill_if_instr", if_instr, 32'hCCCC_0040);
        chk("refill_pc", pc, 32'h44);

        // Redirect to 0x103 during a refill at 0x40.
        step(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h103, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("ff_if_valid", 32'(if_valid), 32'h0);
        chk("ff_pc", pc, 32'h40);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("ff_pc_hold", pc, 32'h40);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hDDDD_0040, 1'b1);
        chk("ff_drop", 32'(if_valid), 32'h0);
        chk("ff_new_pc", pc, 32'h100);

        // Full queue, pop and redirect together.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hEEEE_0100, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'hEEEE_0104, 1'b0);
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("rf_if_valid", 32'(if_valid), 32'h0);
        chk("rf_pc", pc, 32'h200);

        // pc wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 1'b0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic        rv;
            logic        rdy;
            logic        miss;
            rv   = ($urandom_range(0, 15) == 0);
            rdy  = ($urandom_range(0, 9) < 6);
            miss = !rdy && ($urandom_range(0, 4) == 0);
            step(rv, $urandom, rdy, miss, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
